// File: rtl/calc_core.sv
// ----------------------------------------------------------------------------
// calc_core : operand-entry controller and datapath for the seven-segment
// calculator.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   step, clear       : single-cycle strobes from the debounced buttons
//   operand_in[W]     : switch value, captured on step in LOAD_FIRST/LOAD_SECOND
//   op_sel[3]         : operation select, sampled live in CALCULATE
//   state[2]          : FSM state (WAIT=00 LOAD_FIRST=01 LOAD_SECOND=10 CALCULATE=11)
//   num1, num2[W]     : operand registers
//   result[2W]        : registered result, zero-extended
//   result_valid      : result corresponds to the current op_sel and operands
//   flag              : carry (ADD) / borrow (SUB), else 0
//   op_err            : op_sel is reserved or not compiled in
//   busy              : sequential multiply in progress
//
// Strobe protocol: step and clear carry no ready. clear is always accepted
// and wins over step. step is accepted on any rising edge where busy is low;
// while busy is high a step is dropped, not queued.
//
// Build option: define CALC_CORE_MUL_EN to compile the shift-add multiplier
// for op 101. Without it op 101 is reported as reserved and busy is tied low.
// ----------------------------------------------------------------------------
module calc_core #(
  parameter int WIDTH = 8,
  parameter int CHAIN = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               clear,
  input  logic [WIDTH-1:0]   operand_in,
  input  logic [2:0]         op_sel,
  output logic [1:0]         state,
  output logic [WIDTH-1:0]   num1,
  output logic [WIDTH-1:0]   num2,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               flag,
  output logic               op_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_WAIT        = 2'b00,
    ST_LOAD_FIRST  = 2'b01,
    ST_LOAD_SECOND = 2'b10,
    ST_CALCULATE   = 2'b11
  } state_t;

  localparam logic [2:0] OP_XOR = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
`ifdef CALC_CORE_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam int         CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`endif

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_num1;
  logic [WIDTH-1:0]     r_num2;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_flag;
  logic                 r_op_err;
  logic                 r_valid;
  logic [2:0]           r_op_q;     // op the registered result was computed for
  logic                 w_busy;
  logic                 w_step_go;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_alu_res;
  logic                 w_alu_flag;
  logic                 w_alu_err;

`ifdef CALC_CORE_MUL_EN
  logic                 r_busy;
  logic [CW-1:0]        r_mul_cnt;
  logic [2*WIDTH-1:0]   r_mul_acc;
  logic [WIDTH-1:0]     w_mplier;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_mul_sum;

  // Partial product for bit r_mul_cnt of num2: num1 shifted into position.
  assign w_mplier  = r_num2 >> r_mul_cnt;
  assign w_pp      = w_mplier[0] ? ({{WIDTH{1'b0}}, r_num1} << r_mul_cnt) : '0;
  assign w_mul_sum = r_mul_acc + w_pp;
  assign w_busy    = r_busy;
`else
  assign w_busy    = 1'b0;
`endif

  assign w_step_go = step & ~w_busy;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WAIT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_WAIT;
    end else if (w_step_go) begin
      case (r_state)
        ST_WAIT:        w_next_state = ST_LOAD_FIRST;
        ST_LOAD_FIRST:  w_next_state = ST_LOAD_SECOND;
        ST_LOAD_SECOND: w_next_state = ST_CALCULATE;
        ST_CALCULATE:   w_next_state = (CHAIN != 0) ? ST_LOAD_SECOND : ST_LOAD_FIRST;
        default:        w_next_state = ST_WAIT;
      endcase
    end
  end

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    w_alu_res  = '0;
    w_alu_flag = 1'b0;
    w_alu_err  = 1'b0;
    w_sum      = {1'b0, r_num1} + {1'b0, r_num2};
    w_diff     = {1'b0, r_num1} - {1'b0, r_num2};
    case (op_sel)
      OP_XOR: w_alu_res[WIDTH-1:0] = r_num1 ^ r_num2;
      OP_AND: w_alu_res[WIDTH-1:0] = r_num1 & r_num2;
      OP_OR:  w_alu_res[WIDTH-1:0] = r_num1 | r_num2;
      OP_ADD: begin
        w_alu_res[WIDTH:0] = w_sum;
        w_alu_flag         = w_sum[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        w_alu_res[WIDTH-1:0] = w_diff[WIDTH-1:0];
        w_alu_flag           = w_diff[WIDTH];
      end
      default: w_alu_err = 1'b1;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num1   <= '0;
      r_num2   <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_op_err <= 1'b0;
      r_valid  <= 1'b0;
      r_op_q   <= '0;
`ifdef CALC_CORE_MUL_EN
      r_busy    <= 1'b0;
      r_mul_cnt <= '0;
      r_mul_acc <= '0;
`endif
    end else if (clear) begin
      r_num1   <= '0;
      r_num2   <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_op_err <= 1'b0;
      r_valid  <= 1'b0;
      r_op_q   <= '0;
`ifdef CALC_CORE_MUL_EN
      r_busy    <= 1'b0;
      r_mul_cnt <= '0;
      r_mul_acc <= '0;
`endif
    end else begin
      case (r_state)
        ST_LOAD_FIRST: if (step) r_num1 <= operand_in;
        ST_LOAD_SECOND: if (step) r_num2 <= operand_in;
        ST_CALCULATE: begin
          if (w_step_go) begin
            // Leaving CALCULATE: result is held, validity drops.
            r_valid <= 1'b0;
            if (CHAIN != 0) r_num1 <= r_result[WIDTH-1:0];
          end
`ifdef CALC_CORE_MUL_EN
          else if (op_sel == OP_MUL) begin
            if (r_busy) begin
              r_mul_acc <= w_mul_sum;
              r_mul_cnt <= r_mul_cnt + 1'b1;
              if (r_mul_cnt == LAST_BIT) begin
                r_busy   <= 1'b0;
                r_result <= w_mul_sum;
                r_valid  <= 1'b1;
              end
            end else if (!(r_valid && (r_op_q == OP_MUL))) begin
              // Fresh entry or switch to MUL: start; a finished product is held.
              r_busy    <= 1'b1;
              r_mul_cnt <= '0;
              r_mul_acc <= '0;
              r_valid   <= 1'b0;
              r_flag    <= 1'b0;
              r_op_err  <= 1'b0;
              r_op_q    <= OP_MUL;
            end
          end
`endif
          else begin
`ifdef CALC_CORE_MUL_EN
            r_busy   <= 1'b0;   // leaving MUL mid-run aborts it
`endif
            r_result <= w_alu_res;
            r_flag   <= w_alu_flag;
            r_op_err <= w_alu_err;
            r_op_q   <= op_sel;
            r_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state        = r_state;
  assign num1         = r_num1;
  assign num2         = r_num2;
  assign result       = r_result;
  assign flag         = r_flag;
  assign op_err       = r_op_err;
  assign busy         = w_busy;
  // An op_sel change invalidates the held result until it is recomputed.
  assign result_valid = r_valid & (op_sel == r_op_q) & (r_state == ST_CALCULATE);

endmodule

// File: tb/tb_calc_core.sv
module tb_calc_core;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (CHAIN=0)
  logic           step = 1'b0, clear = 1'b0;
  logic [W-1:0]   operand_in = '0;
  logic [2:0]     op_sel = '0;
  logic [1:0]     state;
  logic [W-1:0]   num1, num2;
  logic [2*W-1:0] result;
  logic           result_valid, flag, op_err, busy;

  // chaining DUT (CHAIN=1)
  logic           c_step = 1'b0, c_clear = 1'b0;
  logic [W-1:0]   c_operand = '0;
  logic [2:0]     c_op = '0;
  logic [1:0]     c_state;
  logic [W-1:0]   c_num1, c_num2;
  logic [2*W-1:0] c_result;
  logic           c_valid, c_flag, c_err, c_busy;

  calc_core #(.WIDTH(W), .CHAIN(0)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .clear(clear),
    .operand_in(operand_in), .op_sel(op_sel), .state(state),
    .num1(num1), .num2(num2), .result(result), .result_valid(result_valid),
    .flag(flag), .op_err(op_err), .busy(busy)
  );

  calc_core #(.WIDTH(W), .CHAIN(1)) dut_chain (
    .clk(clk), .rst_n(rst_n), .step(c_step), .clear(c_clear),
    .operand_in(c_operand), .op_sel(c_op), .state(c_state),
    .num1(c_num1), .num2(c_num2), .result(c_result), .result_valid(c_valid),
    .flag(c_flag), .op_err(c_err), .busy(c_busy)
  );

  // ---------------- scoreboard ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference calculator: returns {err, flag, result[15:0]}.
  function automatic logic [31:0] ref_calc(input logic [2:0] op, input int unsigned a,
                                           input int unsigned b);
    int unsigned m = 1 << W;
    int unsigned res = 0;
    logic f = 1'b0, e = 1'b0;
    case (op)
      3'd0: res = a ^ b;
      3'd1: res = a & b;
      3'd2: res = a | b;
      3'd3: begin res = a + b; f = (a + b) >= m; end
      3'd4: begin res = (a + m - b) % m; f = a < b; end
`ifdef CALC_CORE_MUL_EN
      3'd5: res = a * b;
`endif
      default: e = 1'b1;
    endcase
    return {14'd0, e, f, res[15:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic c_do_step();
    c_step = 1'b1; tick(); c_step = 1'b0;
  endtask

  // Let the selected op complete, then compare against the model.
  task automatic expect_result(input string tag, input logic [2:0] op,
                               input int unsigned a, input int unsigned b);
    exp_q.push_back(ref_calc(op, a, b));
`ifdef CALC_CORE_MUL_EN
    if (op == 3'd5) begin
      int cyc = 0;
      tick();
      if (busy === 1'b1) cyc = 1;
      while (busy === 1'b1 && cyc < 40) begin
        tick();
        if (busy === 1'b1) cyc++;
      end
      check({tag, "_busy_cycles"}, 32'(cyc), 32'(W));
    end else tick();
`else
    tick();
`endif
    last_exp = exp_q.pop_front();
    check({tag, "_result"}, 32'(result), {16'd0, last_exp[15:0]});
    check({tag, "_flag"},   32'(flag),   32'(last_exp[16]));
    check({tag, "_err"},    32'(op_err), 32'(last_exp[17]));
    check({tag, "_valid"},  32'(result_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned a, b;
    logic [2:0]  op, op2;
    bit          in_wait;

    // reset state
    #1;
    check("rst_state",  32'(state), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_nums",   32'({num1, num2}), 32'd0);
    check("rst_flags",  32'({result_valid, flag, op_err, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed: 0x0F + 0xF1
    op_sel = 3'd3;
    do_step();
    check("wait_to_lf", 32'(state), 32'd1);
    operand_in = 8'h0F; do_step();
    operand_in = 8'hF1; do_step();
    check("enter_state", 32'(state), 32'd3);
    check("enter_nums",  32'({num1, num2}), 32'h0FF1);
    check("enter_valid_low", 32'(result_valid), 32'd0);
    tick();
    check("add_result", 32'(result), 32'h100);
    check("add_flag",   32'(flag), 32'd1);
    check("add_valid",  32'(result_valid), 32'd1);

    op_sel = 3'd4; #1;
    check("chg_valid_low", 32'(result_valid), 32'd0);
    tick();
    check("sub_result", 32'(result), 32'h1E);
    check("sub_flag",   32'(flag), 32'd1);
    check("sub_valid",  32'(result_valid), 32'd1);
    op_sel = 3'd0; tick();
    check("xor_result", 32'(result), 32'hFE);
    check("xor_flag",   32'(flag), 32'd0);
    op_sel = 3'd6; tick();
    check("rsv_result", 32'(result), 32'd0);
    check("rsv_err",    32'(op_err), 32'd1);
    check("rsv_valid",  32'(result_valid), 32'd1);

    // 0xFF * 0xFF (MUL build) or reserved 101 (default build)
    do_step();
    operand_in = 8'hFF; do_step(); do_step();
    op_sel = 3'd5;
    tick();
    last_exp = ref_calc(3'd5, 255, 255);
    exp_q.push_back(last_exp);
    last_exp = exp_q.pop_front();
`ifdef CALC_CORE_MUL_EN
    begin
      int cyc = 0;
      op_sel = 3'd0; tick();   // leave MUL, then re-select it to run a clean count
      op_sel = 3'd5;
      expect_result("mul_ff", 3'd5, 255, 255);
      check("mul_ff_const", 32'(result), 32'hFE01);
      cyc = 0;
    end
`else
    check("mul_rsv_result", 32'(result), 32'd0);
    check("mul_rsv_err",    32'(op_err), 32'd1);
    check("mul_rsv_model",  32'(op_err), 32'(last_exp[17]));
`endif
    do_step();
    check("calc_to_lf", 32'(state), 32'd1);
    check("calc_step_valid_low", 32'(result_valid), 32'd0);

    // clear wins over step in LOAD_SECOND
    operand_in = 8'h33; do_step();
    check("ls_state", 32'(state), 32'd2);
    step = 1'b1; clear = 1'b1; tick(); step = 1'b0; clear = 1'b0;
    check("clr_state",  32'(state), 32'd0);
    check("clr_nums",   32'({num1, num2}), 32'd0);
    check("clr_result", 32'(result), 32'd0);

    // asynchronous reset mid-CALCULATE
    op_sel = 3'd3;
    do_step(); operand_in = 8'h12; do_step(); operand_in = 8'h34; do_step(); tick();
    check("pre_arst_result", 32'(result), 32'h46);
    #3 rst_n = 1'b0;
    #1;
    check("arst_state",  32'(state), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_nums",   32'({num1, num2}), 32'd0);
    check("arst_flags",  32'({result_valid, flag, op_err, busy}), 32'd0);
    @(negedge clk); rst_n = 1'b1; tick();

    // randomized transactions
    in_wait = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_clear();
        check("rnd_clr_state", 32'(state), 32'd0);
        in_wait = 1'b1;
      end
      if (in_wait) do_step();
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      op = 3'($urandom_range(0, 7));
      operand_in = W'(a); do_step();
      check("rnd_num1", 32'(num1), a);
      operand_in = W'(b); op_sel = op; do_step();
      check("rnd_state", 32'(state), 32'd3);
      check("rnd_num2",  32'(num2), b);
      expect_result("rnd_op", op, a, b);
      op2 = 3'((32'(op) + $urandom_range(1, 7)) % 8);
      op_sel = op2; #1;
      check("rnd_chg_valid_low", 32'(result_valid), 32'd0);
      expect_result("rnd_chg", op2, a, b);
      do_step();
      check("rnd_back_lf", 32'(state), 32'd1);
      check("rnd_hold",    32'(result), {16'd0, last_exp[15:0]});
      in_wait = 1'b0;
    end

    // CHAIN=1: 5+7=12, then 12+3=15
    c_op = 3'd3;
    c_do_step();
    c_operand = 8'd5; c_do_step();
    c_operand = 8'd7; c_do_step();
    tick();
    check("chain_first", 32'(c_result), 32'd12);
    c_do_step();
    check("chain_state", 32'(c_state), 32'd2);
    check("chain_num1",  32'(c_num1), 32'd12);
    c_operand = 8'd3; c_do_step(); tick();
    check("chain_result", 32'(c_result), 32'd15);
    check("chain_valid",  32'(c_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Parametrised calculator datapath and controller for the seven-segment calculator design.
- Sequences operand entry with a 4-state FSM driven by debounced single-cycle button strobes.
- Holds both operands and computes a selectable logic or arithmetic result, registered at the core boundary.
- Downstream display formatting consumes state, num1, num2 and result.

Parameters:
- WIDTH, 8, operand width in bits (valid range 2..16).
- CHAIN, 0: when 1, a step in CALCULATE loads result[WIDTH-1:0] into num1 and jumps to LOAD_SECOND. When 0, a step returns to LOAD_FIRST.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- step  input  1  one-cycle pulse from the debounced right button; advances the FSM.
- clear  input  1  one-cycle pulse from the debounced left button; returns to WAIT.
- operand_in  input  WIDTH  switch value sampled on step.
- op_sel  input  3  operation select, sampled live in CALCULATE.
- state  output  2  FSM state: WAIT=00, LOAD_FIRST=01, LOAD_SECOND=10, CALCULATE=11.
- num1  output  WIDTH  first operand register.
- num2  output  WIDTH  second operand register.
- result  output  2*WIDTH  registered result, zero-extended.
- result_valid  output  1  result matches the current op_sel and operands.
- flag  output  1  carry (ADD) or borrow (SUB); 0 for all other ops.
- op_err  output  1  op_sel is reserved or not compiled in.
- busy  output  1  multi-cycle operation in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): state=WAIT; num1, num2, result=0; result_valid, flag, op_err, busy=0.
- clear has priority over step in the same cycle. From any state it sets state=WAIT, zeroes num1, num2 and result, drops result_valid, flag, op_err and busy, and aborts any multiply.
- WAIT + step -> LOAD_FIRST. No register capture.
- LOAD_FIRST + step -> LOAD_SECOND; num1<=operand_in on the same edge.
- LOAD_SECOND + step -> CALCULATE; num2<=operand_in on the same edge.
- CALCULATE + step:
  - CHAIN=0 -> LOAD_FIRST; result is held.
  - CHAIN=1 -> LOAD_SECOND; num1<=result[WIDTH-1:0].
  - step is ignored while busy=1.
- Outside CALCULATE: result holds its last value and result_valid=0.
- Operation encoding (single-cycle ops recompute every cycle in CALCULATE; result_valid=1 from the first cycle after entry, i.e. 1-cycle latency after the entering edge or after an op_sel change):
  - 000 XOR; 001 AND; 010 OR: result = bitwise op, upper bits 0.
  - 011 ADD: result = num1+num2 as WIDTH+1 bits; flag = bit WIDTH.
  - 100 SUB: result = (num1-num2) mod 2^WIDTH, zero-extended; flag = (num1<num2). Example: WIDTH=8, 3-5 -> 0xFE, flag=1.
  - 101 MUL: see Optional Feature.
  - 110, 111 reserved: result=0, op_err=1, result_valid=1.
- op_sel change in CALCULATE: result_valid drops for exactly one cycle, then the new result is presented.
- No wrap beyond the stated widths; all arithmetic is unsigned.

Optional Feature:
- Macro: CALC_CORE_MUL_EN.
- Defined: op 101 runs a sequential shift-add multiply.
  - Entering CALCULATE with op 101, or switching to 101, sets busy=1 and result_valid=0.
  - One partial product per cycle for WIDTH cycles.
  - On the final cycle: result = num1*num2 (2*WIDTH bits), busy=0, result_valid=1.
  - Changing op_sel away from 101 mid-run aborts the multiply and computes the new op.
  - clear aborts it, as above.
  - The result holds until op_sel or the state changes.
- Undefined: op 101 is treated as reserved (result=0, op_err=1); busy is tied to 0.

Test Plan:
- WIDTH=8: reset; step x3 with operand_in 0x0F then 0xF1; op 011 -> state=11, num1=0x0F, num2=0xF1, result=0x100, flag=1, result_valid=1 one cycle after the entering edge.
- Same operands, op_sel 011->100 -> result_valid=0 for one cycle, then result=0x1E, flag=1; op 000 -> result=0xFE, flag=0.
- step and clear asserted together in LOAD_SECOND -> state=00, num1=num2=result=0.
- rst_n pulled low mid-CALCULATE, asynchronously between clock edges -> all outputs zero immediately, state=00.
- CHAIN=1: 5+7=12, then step, operand 3, step, op 011 -> num1=12, result=15.
- CALC_CORE_MUL_EN defined, WIDTH=8, 0xFF*0xFF -> busy high for 8 cycles, then result=0xFE01 and result_valid=1. Undefined -> op_err=1, result=0.
